uart_tx_arbiter: RTL and testbench

Round-robin arbiter sharing one `uart8n1` transmitter among `NUM_REQ` byte producers. It accepts one byte per grant, drives the UART's `txEn`/`txStart`/data inputs, and tracks the frame to completion through `txBusy`/`txDone`. It reports acceptance and completion per requester. It sits between the application requesters and the UART TX side; the RX side is untouched.

---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the round-robin UART TX arbiter.
package uart_arb_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arbStateT;

  // Width of an index that addresses n requesters; never less than one bit.
  function automatic int unsigned ptrWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-TX side signals of the arbiter. The master modport is the
// arbiter's view; the slave modport is the view of the requesters and the UART.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0]        req;
  logic [BYTE_W*NUM_REQ-1:0] reqData;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        done;
  logic                      busy;
  logic                      timeoutErr;
  logic                      txEn;
  logic                      txStart;
  logic [BYTE_W-1:0]         txData;
  logic                      txBusy;
  logic                      txDone;

  modport master (
    input  req, reqData, txBusy, txDone,
    output ack, done, busy, timeoutErr, txEn, txStart, txData
  );

  modport slave (
    output req, reqData, txBusy, txDone,
    input  ack, done, busy, timeoutErr, txEn, txStart, txData
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ, returned as a one-hot grant plus a valid flag.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W   = ptrWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic               valid_c
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    grant_c = '0;
    valid_c = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!valid_c && req[idx[PTR_W-1:0]]) begin
        grant_c[idx[PTR_W-1:0]] = 1'b1;
        valid_c                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart8n1 transmitter among NUM_REQ byte producers.
// Optional frame watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 250_000
) (
  input logic               clk,
  input logic               rstN,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned PTR_W = ptrWidth(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : gBadNumReq
    $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arbStateT           state;
  arbStateT           nextState;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptrNext;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   ownerNext;
  logic [PTR_W-1:0]   pickOwner;
  logic [BYTE_W-1:0]  pickData;
  logic [BYTE_W-1:0]  txDataNext;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ackNext;
  logic [NUM_REQ-1:0] doneNext;
  logic               pickValid;
  logic               txStartNext;
  logic               busyNext;
  logic               timeoutNext;
  logic               waiting;
  logic               complete;
  logic               launch;
  logic               timeoutHit;

  rr_pick #(.NUM_REQ(NUM_REQ)) uPick (
    .req     (bus.req),
    .ptr     (ptr),
    .grant_c (grant),
    .valid_c (pickValid)
  );

  // Index and byte of the granted requester.
  always_comb begin
    pickOwner = '0;
    pickData  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        pickOwner = PTR_W'(i);
        pickData  = bus.reqData[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // txBusy low in IDLE keeps us off a frame still running from before a reset.
  assign waiting  = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign complete = waiting && bus.txDone;
  assign launch   = (state == IDLE) && pickValid && !bus.txBusy;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] toCnt;

  // Frame watchdog: counts clocks spent waiting on the UART.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      toCnt <= '0;
    end else if (state == LAUNCH) begin
      toCnt <= '0;
    end else if (waiting) begin
      toCnt <= toCnt + 1'b1;
    end
  end

  assign timeoutHit = waiting && !bus.txDone && (toCnt >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state          <= IDLE;
      ptr            <= '0;
      owner          <= '0;
      bus.ack        <= '0;
      bus.done       <= '0;
      bus.busy       <= 1'b0;
      bus.timeoutErr <= 1'b0;
      bus.txEn       <= 1'b0;
      bus.txStart    <= 1'b0;
      bus.txData     <= '0;
    end else begin
      state          <= nextState;
      ptr            <= ptrNext;
      owner          <= ownerNext;
      bus.ack        <= ackNext;
      bus.done       <= doneNext;
      bus.busy       <= busyNext;
      bus.timeoutErr <= timeoutNext;
      bus.txEn       <= 1'b1;
      bus.txStart    <= txStartNext;
      bus.txData     <= txDataNext;
    end
  end

  // Next-state logic; a txDone seen before txBusy still completes the frame.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:      if (launch) nextState = LAUNCH;
      LAUNCH:    nextState = WAIT_BUSY;
      WAIT_BUSY: begin
        if (complete || timeoutHit) nextState = IDLE;
        else if (bus.txBusy)        nextState = WAIT_DONE;
      end
      WAIT_DONE: if (complete || timeoutHit) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Next values of the registered outputs and the grant bookkeeping.
  always_comb begin
    ackNext     = '0;
    doneNext    = '0;
    txStartNext = 1'b0;
    timeoutNext = timeoutHit;
    busyNext    = (nextState != IDLE);
    txDataNext  = bus.txData;
    ownerNext   = owner;
    ptrNext     = ptr;
    if (launch) begin
      ackNext    = grant;
      ownerNext  = pickOwner;
      txDataNext = pickData;
    end
    if (state == LAUNCH) begin
      txStartNext = 1'b1;
    end
    if (complete) begin
      doneNext[owner] = 1'b1;
    end
    if (complete || timeoutHit) begin
      ptrNext = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small requester model and UART stub.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned FRAME = 6;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(100)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  logic [NREQ-1:0]   reqV     = '0;
  logic [8*NREQ-1:0] dataV    = '0;
  logic [NREQ-1:0]   withdraw = '0;
  logic autoUart = 1'b0;
  logic autoBusy = 1'b0;
  logic autoDone = 1'b0;
  logic manBusy  = 1'b0;
  logic manDone  = 1'b0;
  int   target[NREQ];
  int   sent[NREQ];

  assign bus.req     = reqV;
  assign bus.reqData = dataV;
  assign bus.txBusy  = autoBusy | manBusy;
  assign bus.txDone  = autoDone | manDone;

  // Requester i keeps req high while it has bytes left and is not withdrawn.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.ack[i]) sent[i]++;
      reqV[i] = (sent[i] < target[i]) && !withdraw[i];
    end
  end

  // UART stub: busy for FRAME cycles after txStart, then a one-cycle txDone.
  always begin
    @(negedge clk);
    if (autoUart && bus.txStart) begin
      autoBusy = 1'b1;
      repeat (FRAME) @(negedge clk);
      autoBusy = 1'b0;
      autoDone = 1'b1;
      @(negedge clk);
      autoDone = 1'b0;
    end
  end

  logic [NREQ-1:0] ackLog[$];
  logic [NREQ-1:0] doneLog[$];
  logic [7:0]      byteLog[$];
  int              toCount = 0;

  always @(negedge clk) begin
    if (bus.ack != '0)  ackLog.push_back(bus.ack);
    if (bus.done != '0) doneLog.push_back(bus.done);
    if (bus.txStart)    byteLog.push_back(bus.txData);
    if (bus.timeoutErr) toCount++;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic doReset();
    rstN = 1'b0;
    ticks(2);
    rstN = 1'b1;
  endtask

  task automatic waitAcks(input int goal, input string tag);
    int k = 0;
    while (ackLog.size() < goal && k < 400) begin
      tick();
      k++;
    end
    checkEq({tag, " ack wait"}, 32'(ackLog.size() >= goal), 32'd1);
  endtask

  task automatic waitDones(input int goal, input string tag);
    int k = 0;
    while (doneLog.size() < goal && k < 400) begin
      tick();
      k++;
    end
    checkEq({tag, " done wait"}, 32'(doneLog.size() >= goal), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin
    int aBase;
    int bBase;
    int dBase;
    int tBase;
    int k;
    int acksSeen;

    // Reset values
    ticks(2);
    checkEq("rst ack", 32'(bus.ack), 32'h0);
    checkEq("rst done", 32'(bus.done), 32'h0);
    checkEq("rst busy", 32'(bus.busy), 32'h0);
    checkEq("rst timeoutErr", 32'(bus.timeoutErr), 32'h0);
    checkEq("rst txEn", 32'(bus.txEn), 32'h0);
    checkEq("rst txStart", 32'(bus.txStart), 32'h0);
    checkEq("rst txData", 32'(bus.txData), 32'h0);
    rstN = 1'b1;
    tick();
    checkEq("txEn after reset", 32'(bus.txEn), 32'h1);
    checkEq("idle busy", 32'(bus.busy), 32'h0);

    // Single request with cycle-exact timing, manual UART
    dataV[15:8] = 8'hA5;
    target[1]   = sent[1] + 1;
    tick();
    checkEq("single ack", 32'(bus.ack), 32'h2);
    checkEq("single txData", 32'(bus.txData), 32'hA5);
    checkEq("single txStart early", 32'(bus.txStart), 32'h0);
    checkEq("single busy", 32'(bus.busy), 32'h1);
    tick();
    checkEq("single ack one cycle", 32'(bus.ack), 32'h0);
    checkEq("single txStart", 32'(bus.txStart), 32'h1);
    tick();
    checkEq("single txStart one cycle", 32'(bus.txStart), 32'h0);
    manBusy = 1'b1;
    ticks(3);
    checkEq("single no early done", 32'(bus.done), 32'h0);
    manBusy = 1'b0;
    manDone = 1'b1;
    tick();
    manDone = 1'b0;
    checkEq("single done", 32'(bus.done), 32'h2);
    checkEq("single idle after done", 32'(bus.busy), 32'h0);
    checkEq("single txData held", 32'(bus.txData), 32'hA5);
    tick();
    checkEq("single done one cycle", 32'(bus.done), 32'h0);

    // Stray txDone while idle is ignored
    manDone = 1'b1;
    tick();
    manDone = 1'b0;
    tick();
    checkEq("stray txDone done", 32'(bus.done), 32'h0);
    checkEq("stray txDone busy", 32'(bus.busy), 32'h0);

    // All four at once after reset: order 0,1,2,3
    doReset();
    autoUart = 1'b1;
    aBase = ackLog.size();
    bBase = byteLog.size();
    dBase = doneLog.size();
    dataV = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < NREQ; i++) target[i] = sent[i] + 1;
    waitDones(dBase + 4, "all4");
    checkEq("all4 ack count", 32'(ackLog.size() - aBase), 32'd4);
    for (int i = 0; i < NREQ; i++) begin
      checkEq($sformatf("all4 grant %0d", i), 32'(ackLog[aBase+i]), 32'(1 << i));
      checkEq($sformatf("all4 byte %0d", i), 32'(byteLog[bBase+i]), 32'(8'h10 + i));
    end

    // Fairness: 0 and 2 held continuously alternate
    aBase = ackLog.size();
    bBase = byteLog.size();
    dBase = doneLog.size();
    dataV = {8'h33, 8'h32, 8'h31, 8'h30};
    target[0] = sent[0] + 3;
    target[2] = sent[2] + 3;
    waitDones(dBase + 6, "fair");
    checkEq("fair ack count", 32'(ackLog.size() - aBase), 32'd6);
    for (int i = 0; i < 6; i++) begin
      checkEq($sformatf("fair grant %0d", i), 32'(ackLog[aBase+i]), (i % 2 == 0) ? 32'h1 : 32'h4);
      checkEq($sformatf("fair byte %0d", i), 32'(byteLog[bBase+i]), (i % 2 == 0) ? 32'h30 : 32'h32);
    end

    // Withdrawal: 3 drops mid-frame, so 1 wins though ptr points at 3
    aBase = ackLog.size();
    dBase = doneLog.size();
    target[2] = sent[2] + 1;
    waitAcks(aBase + 1, "wd first");
    tick();
    target[1] = sent[1] + 1;
    target[3] = sent[3] + 1;
    ticks(2);
    withdraw[3] = 1'b1;
    waitDones(dBase + 2, "wd");
    ticks(20);
    checkEq("wd ack count", 32'(ackLog.size() - aBase), 32'd2);
    checkEq("wd grant 0", 32'(ackLog[aBase]), 32'h4);
    checkEq("wd grant 1", 32'(ackLog[aBase+1]), 32'h2);

    // Reset while the UART frame is in flight
    aBase = ackLog.size();
    target[0] = sent[0] + 1;
    waitAcks(aBase + 1, "rmf first");
    k = 0;
    while (!bus.txBusy && k < 50) begin
      tick();
      k++;
    end
    checkEq("rmf busy seen", 32'(bus.txBusy), 32'h1);
    rstN = 1'b0;
    #1;
    checkEq("rmf ack", 32'(bus.ack), 32'h0);
    checkEq("rmf done", 32'(bus.done), 32'h0);
    checkEq("rmf busy", 32'(bus.busy), 32'h0);
    checkEq("rmf txEn", 32'(bus.txEn), 32'h0);
    checkEq("rmf txStart", 32'(bus.txStart), 32'h0);
    checkEq("rmf txData", 32'(bus.txData), 32'h0);
    tick();
    rstN = 1'b1;
    aBase = ackLog.size();
    dBase = doneLog.size();
    target[1] = sent[1] + 1;
    acksSeen = 0;
    k = 0;
    while (bus.txBusy && k < 50) begin
      tick();
      if (bus.ack != '0 && bus.txBusy) acksSeen++;
      k++;
    end
    checkEq("rmf no launch while txBusy", 32'(acksSeen), 32'd0);
    waitDones(dBase + 1, "rmf");
    checkEq("rmf grant", 32'(ackLog[aBase]), 32'h2);
    checkEq("rmf done owner", 32'(doneLog[dBase]), 32'h2);

    // Watchdog: UART never answers
    autoUart = 1'b0;
    ticks(2);
    aBase = ackLog.size();
    target[2] = sent[2] + 1;
    waitAcks(aBase + 1, "wdog");
    dBase = doneLog.size();
    tBase = toCount;
    ticks(150);
`ifdef UART_ARB_TIMEOUT_EN
    checkEq("wdog timeout pulses", 32'(toCount - tBase), 32'd1);
    checkEq("wdog no done", 32'(doneLog.size() - dBase), 32'd0);
    checkEq("wdog back to idle", 32'(bus.busy), 32'h0);
`else
    checkEq("wdog no timeout", 32'(toCount - tBase), 32'd0);
    checkEq("wdog no done", 32'(doneLog.size() - dBase), 32'd0);
    checkEq("wdog still waiting", 32'(bus.busy), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
